// File: rtl/block_unpacker_if.sv
// Handshake bundle for block_unpacker: wide packed input word stream and narrow
// single-block output stream. The slave modport is the unpacker side.
interface block_unpacker_if #(
  parameter int BLOCK_SIZE = 128,
  parameter int NUM_BLOCKS = 8
);
  logic                             in_ready;
  logic [NUM_BLOCKS*BLOCK_SIZE-1:0] in_data;
  logic                             in_valid;
  logic [31:0]                      in_num;
  logic                             in_last;
  logic                             ready_4_output;
  logic [BLOCK_SIZE-1:0]            out_data;
  logic                             out_valid;
  logic [31:0]                      out_num;
  logic                             out_last;

  modport master (
    input  in_ready,
    output in_data, in_valid, in_num, in_last, ready_4_output,
    input  out_data, out_valid, out_num, out_last
  );

  modport slave (
    output in_ready,
    input  in_data, in_valid, in_num, in_last, ready_4_output,
    output out_data, out_valid, out_num, out_last
  );
endinterface

// File: rtl/block_unpacker.sv
// Wide-to-narrow block serializer: emits the low-aligned valid blocks of each word
// one per cycle with packet framing. Define BLOCK_UNPACK_STATS_EN for err_ovf/blk_cnt.
module block_unpacker #(
  parameter int BLOCK_SIZE = 128,
  parameter int NUM_BLOCKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  block_unpacker_if.slave bus
`ifdef BLOCK_UNPACK_STATS_EN
  ,
  output logic        err_ovf,
  output logic [31:0] blk_cnt
`endif
);
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int NW = IW + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                           state, state_nxt;
  logic                             live;
  logic [NUM_BLOCKS*BLOCK_SIZE-1:0] hold;
  logic [NW-1:0]                    num_q;
  logic                             last_q;
  logic [IW-1:0]                    idx;
  logic [31:0]                      pkt_cnt;
  logic [NW-1:0]                    in_num_clamp;
  logic                             in_fire, out_fire, final_blk, empty_word, over;

  assign over         = bus.in_num > 32'(NUM_BLOCKS);
  assign in_num_clamp = over ? NW'(NUM_BLOCKS) : bus.in_num[NW-1:0];
  assign empty_word   = (num_q == '0);
  assign final_blk    = empty_word || ({1'b0, idx} == num_q - NW'(1));
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.ready_4_output;

  // Input readiness is gated by 'live' so in_ready stays low until the first edge after reset.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data = '0;
    bus.out_num  = '0;
    bus.out_last = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = live;
        if (live && bus.in_valid)
          state_nxt = EMIT;
      end
      EMIT: begin
        if (empty_word) begin
          bus.out_valid = last_q;
          bus.out_last  = last_q;
        end else begin
          bus.out_valid = 1'b1;
          bus.out_data  = hold[idx*BLOCK_SIZE +: BLOCK_SIZE];
          bus.out_num   = pkt_cnt + 32'd1;
          bus.out_last  = last_q && final_blk;
        end
        if (empty_word && !last_q) begin
          state_nxt = IDLE;
        end else if (bus.ready_4_output && final_blk) begin
          bus.in_ready = live;
          state_nxt    = bus.in_valid ? EMIT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      live    <= 1'b0;
      hold    <= '0;
      num_q   <= '0;
      last_q  <= 1'b0;
      idx     <= '0;
      pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (out_fire) begin
        if (final_blk) begin
          pkt_cnt <= last_q ? 32'd0 : pkt_cnt + 32'd1;
        end else begin
          idx     <= idx + IW'(1);
          pkt_cnt <= pkt_cnt + 32'd1;
        end
      end
      // A new word may latch in the same cycle the previous word's final block fires.
      if (in_fire) begin
        hold   <= bus.in_data;
        num_q  <= in_num_clamp;
        last_q <= bus.in_last;
        idx    <= '0;
      end
    end
  end

`ifdef BLOCK_UNPACK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      blk_cnt <= '0;
    end else begin
      if (in_fire && over)
        err_ovf <= 1'b1;
      if (out_fire)
        blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_block_unpacker.sv
// Randomized scoreboard bench for block_unpacker: a driver pushes the expected beats
// of every accepted word, an independent monitor pops and compares each output fire.
module tb_block_unpacker;
  localparam int BS = 128;
  localparam int NB = 8;

  typedef struct {
    logic [BS-1:0] data;
    logic [31:0]   num;
    logic          last;
  } beat_t;

  logic clk;
  logic rst_n;
  block_unpacker_if #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB)) bus ();
`ifdef BLOCK_UNPACK_STATS_EN
  logic        err_ovf;
  logic [31:0] blk_cnt;
`endif

  block_unpacker #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef BLOCK_UNPACK_STATS_EN
    ,
    .err_ovf (err_ovf),
    .blk_cnt (blk_cnt)
`endif
  );

  beat_t       exp_q[$];
  int          fire_log[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;
  int          fires = 0;
  int unsigned model_pkt = 0;
  logic        exp_ovf = 1'b0;
  int          ready_mode = 0;
  logic        stalled = 1'b0;
  beat_t       held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  // ready_4_output pattern: 0 = always high, 1 = toggling, 2 = random (70% high)
  initial bus.ready_4_output = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.ready_4_output = 1'b1;
      1:       bus.ready_4_output = ~bus.ready_4_output;
      default: bus.ready_4_output = ($urandom_range(0, 9) < 7);
    endcase
  end

  task automatic check_output(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic report_fail(input string name, input int act, input int exp);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
  endtask

  // Expected beats come straight from the word: min(num,NB) blocks, 1-based packet index.
  task automatic model_word(input logic [NB*BS-1:0] d, input int unsigned num, input bit last);
    int unsigned n;
    beat_t b;
    n = (num > NB) ? NB : num;
    if (num > NB) exp_ovf = 1'b1;
    if (n == 0) begin
      if (last) begin
        b.data = '0; b.num = 0; b.last = 1'b1;
        exp_q.push_back(b);
        model_pkt = 0;
      end
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        model_pkt = model_pkt + 1;
        b.data = d[k*BS +: BS];
        b.num  = model_pkt;
        b.last = last && (k == int'(n) - 1);
        exp_q.push_back(b);
      end
      if (last) model_pkt = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge on which the word fired.
  task automatic apply_stimulus(input int unsigned num, input bit last);
    logic [NB*BS-1:0] d;
    bit accepted;
    for (int i = 0; i < NB*BS/32; i++) d[i*32 +: 32] = $urandom;
    bus.in_data  = d;
    bus.in_num   = num;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    accepted = 1'b0;
    for (int w = 0; w < 200 && !accepted; w++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        model_word(d, num, last);
        accepted = 1'b1;
      end
    end
    if (!accepted) report_fail("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 400 && !done; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.out_valid === 1'b0) done = 1'b1;
    end
    if (!done) report_fail("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef BLOCK_UNPACK_STATS_EN
    check_output("err_ovf", BS'(err_ovf), BS'(exp_ovf));
    check_output("blk_cnt", BS'(blk_cnt), BS'(fires));
`endif
  endtask

  // Monitor: decide at the falling edge whether the beat fires on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fire_log.delete();
      stalled = 1'b0;
      fires = 0;
    end else begin
      if (stalled) begin
        check_output("stall_valid", BS'(bus.out_valid), BS'(1'b1));
        check_output("stall_data", bus.out_data, held.data);
        check_output("stall_num", BS'(bus.out_num), BS'(held.num));
        check_output("stall_last", BS'(bus.out_last), BS'(held.last));
      end
      stalled = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (bus.ready_4_output === 1'b1) begin
          beat_t e;
          fires++;
          fire_log.push_back(cycle);
          if (exp_q.size() == 0) begin
            report_fail("unexpected_beat", int'(bus.out_num), -1);
          end else begin
            e = exp_q.pop_front();
            check_output("out_data", bus.out_data, e.data);
            check_output("out_num", BS'(bus.out_num), BS'(e.num));
            check_output("out_last", BS'(bus.out_last), BS'(e.last));
          end
        end else begin
          stalled   = 1'b1;
          held.data = bus.out_data;
          held.num  = bus.out_num;
          held.last = bus.out_last;
        end
      end
    end
  end

  initial begin
    int f0;
    bit reached;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_num   = '0;
    bus.in_last  = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    check_output("rst_in_ready", BS'(bus.in_ready), '0);
    check_output("rst_out_valid", BS'(bus.out_valid), '0);
    check_output("rst_out_data", bus.out_data, '0);
    check_output("rst_out_num", BS'(bus.out_num), '0);
    check_output("rst_out_last", BS'(bus.out_last), '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("in_ready_after_rst", BS'(bus.in_ready), BS'(1'b1));

    // Full word, single packet
    apply_stimulus(8, 1'b1);
    wait_drain();

    // Two words streamed with no bubble
    fire_log.delete();
    apply_stimulus(3, 1'b0);
    apply_stimulus(2, 1'b1);
    wait_drain();
    check_output("stream_beats", BS'(fire_log.size()), BS'(5));
    if (fire_log.size() == 5)
      check_output("stream_span", BS'(fire_log[4] - fire_log[0]), BS'(4));

    // Stalled output must hold
    ready_mode = 1;
    apply_stimulus(4, 1'b1);
    wait_drain();
    ready_mode = 0;

    // Dropped empty word, then empty terminator
    apply_stimulus(0, 1'b0);
    apply_stimulus(0, 1'b1);
    wait_drain();

    // Overflow count clamps to NB blocks
    apply_stimulus(12, 1'b1);
    wait_drain();
    check_stats();

    // Reset mid-word
    f0 = fires;
    apply_stimulus(8, 1'b1);
    reached = 1'b0;
    for (int w = 0; w < 50 && !reached; w++) begin
      @(negedge clk);
      if (fires >= f0 + 3) reached = 1'b1;
    end
    if (!reached) report_fail("mid_word_timeout", fires - f0, 3);
    #2 rst_n = 1'b0;
    model_pkt = 0;
    exp_ovf = 1'b0;
    #1;
    check_output("mid_rst_out_valid", BS'(bus.out_valid), '0);
    check_output("mid_rst_out_num", BS'(bus.out_num), '0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("mid_rst_in_ready", BS'(bus.in_ready), BS'(1'b1));
    apply_stimulus(2, 1'b1);
    wait_drain();

    // Randomized traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++)
      apply_stimulus($urandom_range(0, 12), 1'($urandom_range(0, 1)));
    apply_stimulus(1, 1'b1);
    wait_drain();
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got %0d cycles expected completion", cycle);
    $fatal(1, "[TB] timeout");
  end
endmodule
